// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_pkg : shared I2C target types and bus-level constants            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    START        = 4'd1,
    RX_DEV_ADDR  = 4'd2,
    DEV_ADDR_ACK = 4'd3,
    RX_PTR       = 4'd4,
    PTR_ACK      = 4'd5,
    RX_DATA      = 4'd6,
    RX_DATA_ACK  = 4'd7,
    TX_DATA      = 4'd8,
    TX_ACK       = 4'd9,
    WAIT_STOP    = 4'd10
  } state_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_bus_sync : 3-flop SCL/SDA synchroniser with edge and START/STOP  |
// | detection, shared by all bus targets                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_rise,
  output logic scl_fall,
  output logic scl_high,
  output logic sda_in,
  output logic start_det,
  output logic stop_det
);

  logic [2:0] r_scl_sync;
  logic [2:0] r_sda_sync;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], scl_raw};
      r_sda_sync <= {r_sda_sync[1:0], sda_raw};
    end
  end

  logic w_scl_steady_high;
  assign w_scl_steady_high = r_scl_sync[2] & r_scl_sync[1];

  assign scl_rise  = ~r_scl_sync[2] &  r_scl_sync[1];
  assign scl_fall  =  r_scl_sync[2] & ~r_scl_sync[1];
  assign scl_high  =  r_scl_sync[1];
  assign sda_in    =  r_sda_sync[1];
  assign start_det =  w_scl_steady_high &  r_sda_sync[2] & ~r_sda_sync[1];
  assign stop_det  =  w_scl_steady_high & ~r_sda_sync[2] &  r_sda_sync[1];

endmodule
`default_nettype wire

// File: rtl/i2c_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_reg_slave : I2C target exposing NUM_REGS 8-bit registers with    |
// | pointer write, auto-increment burst write/read and repeated START    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int         NUM_REGS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [NUM_REGS*8-1:0] reg_out,
  input  logic [NUM_REGS*8-1:0] reg_in,
  output logic [NUM_REGS-1:0]   wr_strobe,
  output logic                  debug_addr_match,
  output logic [3:0]            debug_state
);

  localparam int               PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_REGS - 1);
  localparam logic [7:0]       NUM_REGS_B = 8'(NUM_REGS);

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_scl_high;
  logic w_sda_in;
  logic w_start_det;
  logic w_stop_det;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_raw   (scl),
    .sda_raw   (sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .scl_high  (w_scl_high),
    .sda_in    (w_sda_in),
    .start_det (w_start_det),
    .stop_det  (w_stop_det)
  );

  state_t                r_state;
  logic [3:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic [7:0]            r_tx_shift;
  logic [PTR_W-1:0]      r_ptr;
  logic                  r_rw;
  logic                  r_sda_oe;
  logic                  r_addr_match;
  logic [NUM_REGS*8-1:0] r_reg_out;
  logic [NUM_REGS-1:0]   r_wr_strobe;

  logic [PTR_W-1:0] w_ptr_next;
  logic [7:0]       w_rd_cur;
  logic [7:0]       w_rd_next;
  logic             w_rx_state;
  logic             w_byte_done;

  assign w_ptr_next  = (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
  assign w_rd_cur    = reg_in[{r_ptr, 3'b000} +: 8];
  assign w_rd_next   = reg_in[{w_ptr_next, 3'b000} +: 8];
  assign w_rx_state  = (r_state == RX_DEV_ADDR) || (r_state == RX_PTR) || (r_state == RX_DATA);
  assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_tx_shift   <= 8'd0;
      r_ptr        <= '0;
      r_rw         <= I2C_WRITE;
      r_sda_oe     <= 1'b0;
      r_addr_match <= 1'b0;
      r_reg_out    <= '0;
      r_wr_strobe  <= '0;
    end else begin
      r_wr_strobe <= '0;
      if (w_stop_det) begin
        r_state      <= IDLE;
        r_sda_oe     <= 1'b0;
        r_addr_match <= 1'b0;
      end else if (w_start_det) begin
        r_state      <= START;
        r_bit_cnt    <= 4'd0;
        r_sda_oe     <= 1'b0;
        r_addr_match <= 1'b0;
      end else begin
        // Receive states sample SDA on every SCL rise until a full byte is held.
        if (w_rx_state && w_scl_rise && (r_bit_cnt != 4'd8)) begin
          r_shift   <= {r_shift[6:0], w_sda_in};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end

        case (r_state)
          START: begin
            if (!w_scl_high) r_state <= RX_DEV_ADDR;
          end

          RX_DEV_ADDR: begin
            if (w_byte_done) begin
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_state      <= DEV_ADDR_ACK;
                r_sda_oe     <= 1'b1;
                r_addr_match <= 1'b1;
                r_rw         <= r_shift[0];
              end else begin
                r_state <= WAIT_STOP;
              end
            end
          end

          DEV_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw == I2C_WRITE) begin
                r_sda_oe <= 1'b0;
                r_state  <= RX_PTR;
              end else begin
                // The fall ending the ACK also launches the first data bit.
                r_sda_oe   <= ~w_rd_cur[7];
                r_tx_shift <= {w_rd_cur[6:0], 1'b0};
                r_bit_cnt  <= 4'd1;
                r_state    <= TX_DATA;
              end
            end
          end

          RX_PTR: begin
            if (w_byte_done) begin
              r_bit_cnt <= 4'd0;
              if (r_shift < NUM_REGS_B) begin
                r_sda_oe <= 1'b1;
                r_ptr    <= r_shift[PTR_W-1:0];
                r_state  <= PTR_ACK;
              end else begin
                r_state <= WAIT_STOP;
              end
            end
          end

          PTR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= RX_DATA;
            end
          end

          RX_DATA: begin
            if (w_byte_done) begin
              r_sda_oe <= 1'b1;
              r_state  <= RX_DATA_ACK;
            end
          end

          RX_DATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe                        <= 1'b0;
              r_reg_out[{r_ptr, 3'b000} +: 8] <= r_shift;
              r_wr_strobe[r_ptr]              <= 1'b1;
              r_ptr                           <= w_ptr_next;
              r_bit_cnt                       <= 4'd0;
              r_state                         <= RX_DATA;
            end
          end

          TX_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= TX_ACK;
              end else begin
                r_sda_oe   <= ~r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt + 4'd1;
              end
            end
          end

          TX_ACK: begin
            if (w_scl_rise) begin
              if (w_sda_in == I2C_ACK) begin
                r_ptr      <= w_ptr_next;
                r_tx_shift <= w_rd_next;
                r_bit_cnt  <= 4'd0;
                r_state    <= TX_DATA;
              end else begin
                r_state <= WAIT_STOP;
              end
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

  assign sda              = r_sda_oe ? 1'b0 : 1'bz;
  assign reg_out          = r_reg_out;
  assign wr_strobe        = r_wr_strobe;
  assign debug_addr_match = r_addr_match;
  assign debug_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2c_reg_slave : bit-banged I2C master driving i2c_reg_slave with  |
// | table-driven write vectors plus wrap, read and reset sequences       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2c_reg_slave;
  import i2c_pkg::*;

  localparam int NR = 4;
  localparam int T  = 200;

  logic          clk;
  logic          rst_n;
  logic          scl;
  logic          m_sda_low;
  wire           sda;
  logic [NR*8-1:0] reg_out;
  logic [NR*8-1:0] reg_in;
  logic [NR-1:0]   wr_strobe;
  logic            debug_addr_match;
  logic [3:0]      debug_state;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_reg_slave #(
    .SLAVE_ADDR (7'h55),
    .NUM_REGS   (NR)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .scl              (scl),
    .sda              (sda),
    .reg_out          (reg_out),
    .reg_in           (reg_in),
    .wr_strobe        (wr_strobe),
    .debug_addr_match (debug_addr_match),
    .debug_state      (debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int strobe_hits [NR];
  initial for (int i = 0; i < NR; i++) strobe_hits[i] = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (wr_strobe[i] === 1'b1) strobe_hits[i]++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    #T m_sda_low = 1'b1;
    #T scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    #(T/2) m_sda_low = 1'b0;
    #(T/2) scl = 1'b1;
    #T m_sda_low = 1'b1;
    #T scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #(T/2) m_sda_low = 1'b1;
    #(T/2) scl = 1'b1;
    #T m_sda_low = 1'b0;
    #T;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      #(T/2) m_sda_low = ~b[i];
      #(T/2) scl = 1'b1;
      #T scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    #(T/2) m_sda_low = 1'b0;
    #(T/2) scl = 1'b1;
    #(T/2) ack = sda;
    #(T/2) scl = 1'b0;
  endtask

  task automatic recv_byte(input logic ack_in, output logic [7:0] d);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #T scl = 1'b1;
      #(T/2) d[i] = sda;
      #(T/2) scl = 1'b0;
    end
    #(T/2) m_sda_low = (ack_in == I2C_ACK);
    #(T/2) scl = 1'b1;
    #T scl = 1'b0;
    #(T/2) m_sda_low = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  ptr;
    logic [7:0]  data;
    logic        ack_addr;
    logic        ack_ptr;
    logic        ack_data;
    logic [3:0]  exp_state;
    logic        exp_match;
    logic [31:0] exp_regs;
    logic [3:0]  exp_strobe;
  } vec_t;

  vec_t vecs [5];
  int   hits0 [NR];

  task automatic snap_hits();
    for (int i = 0; i < NR; i++) hits0[i] = strobe_hits[i];
  endtask

  task automatic strobe_delta(output logic [3:0] seen, output int total);
    seen  = '0;
    total = 0;
    for (int i = 0; i < NR; i++) begin
      if (strobe_hits[i] != hits0[i]) seen[i] = 1'b1;
      total += strobe_hits[i] - hits0[i];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] d;
    logic [3:0] seen;
    int         total;

    rst_n     = 1'b0;
    scl       = 1'b1;
    m_sda_low = 1'b0;
    reg_in    = 32'h4433_2211;

    vecs[0] = '{8'hAA, 8'h01, 8'h3C, 1'b0, 1'b0, 1'b0, RX_DATA,   1'b1, 32'h0000_3C00, 4'b0010};
    vecs[1] = '{8'hAA, 8'h02, 8'hA5, 1'b0, 1'b0, 1'b0, RX_DATA,   1'b1, 32'h00A5_3C00, 4'b0100};
    vecs[2] = '{8'hAA, 8'h07, 8'h99, 1'b0, 1'b1, 1'b1, WAIT_STOP, 1'b1, 32'h00A5_3C00, 4'b0000};
    vecs[3] = '{8'hA8, 8'h00, 8'h77, 1'b1, 1'b1, 1'b1, WAIT_STOP, 1'b0, 32'h00A5_3C00, 4'b0000};
    vecs[4] = '{8'hAA, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, RX_DATA,   1'b1, 32'h00A5_3C5A, 4'b0001};

    repeat (5) @(posedge clk);
    #1;
    check("reset reg_out",    reg_out, 32'h0);
    check("reset wr_strobe",  32'(wr_strobe), 32'h0);
    check("reset state",      32'(debug_state), 32'(IDLE));
    check("reset addr_match", 32'(debug_addr_match), 32'h0);
    check("reset sda",        32'(sda), 32'h1);
    rst_n = 1'b1;
    #T;

    for (int v = 0; v < 5; v++) begin
      snap_hits();
      i2c_start();
      send_byte(vecs[v].addr, a0);
      send_byte(vecs[v].ptr,  a1);
      send_byte(vecs[v].data, a2);
      #(T/2);
      check($sformatf("v%0d addr ack", v),   32'(a0), 32'(vecs[v].ack_addr));
      check($sformatf("v%0d ptr ack", v),    32'(a1), 32'(vecs[v].ack_ptr));
      check($sformatf("v%0d data ack", v),   32'(a2), 32'(vecs[v].ack_data));
      check($sformatf("v%0d state", v),      32'(debug_state), 32'(vecs[v].exp_state));
      check($sformatf("v%0d addr_match", v), 32'(debug_addr_match), 32'(vecs[v].exp_match));
      i2c_stop();
      strobe_delta(seen, total);
      check($sformatf("v%0d reg_out", v),      reg_out, vecs[v].exp_regs);
      check($sformatf("v%0d strobe bits", v),  32'(seen), 32'(vecs[v].exp_strobe));
      check($sformatf("v%0d strobe clks", v),  32'(total), 32'($countones(vecs[v].exp_strobe)));
      check($sformatf("v%0d idle after P", v), 32'(debug_state), 32'(IDLE));
    end

    // Burst write starting at the last register wraps to register 0.
    snap_hits();
    i2c_start();
    send_byte(8'hAA, a0);
    send_byte(8'h03, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    i2c_stop();
    strobe_delta(seen, total);
    check("wrap acks",        32'({a0, a1, a2, a3}), 32'h0);
    check("wrap reg_out",     reg_out, 32'h11A5_3C22);
    check("wrap strobe bits", 32'(seen), 32'b1001);
    check("wrap strobe clks", 32'(total), 32'd2);
    // Pointer now rests at 1, so a bare read returns reg_in byte 1.
    i2c_start();
    send_byte(8'hAB, a0);
    recv_byte(I2C_NACK, d);
    i2c_stop();
    check("ptr after wrap ack",  32'(a0), 32'h0);
    check("ptr after wrap data", 32'(d), 32'h22);

    // Pointer set, repeated START, three-byte read ending with NACK.
    i2c_start();
    send_byte(8'hAA, a0);
    send_byte(8'h00, a1);
    i2c_rstart();
    send_byte(8'hAB, a2);
    check("rd setup acks", 32'({a0, a1, a2}), 32'h0);
    recv_byte(I2C_ACK, d);
    check("rd byte0", 32'(d), 32'h11);
    recv_byte(I2C_ACK, d);
    check("rd byte1", 32'(d), 32'h22);
    recv_byte(I2C_NACK, d);
    check("rd byte2", 32'(d), 32'h33);
    #(T/2);
    check("rd sda released", 32'(sda), 32'h1);
    check("rd wait_stop",    32'(debug_state), 32'(WAIT_STOP));
    i2c_stop();
    check("rd idle", 32'(debug_state), 32'(IDLE));
    // The NACKed byte does not advance the pointer.
    i2c_start();
    send_byte(8'hAB, a0);
    recv_byte(I2C_NACK, d);
    i2c_stop();
    check("rd no inc after nack", 32'(d), 32'h33);

    // Reset in the middle of a data byte.
    i2c_start();
    send_byte(8'hAA, a0);
    send_byte(8'h00, a1);
    send_bits(8'h5A, 4);
    #(T/4) rst_n = 1'b0;
    #1;
    check("mid rst sda",     32'(sda), 32'h1);
    check("mid rst reg_out", reg_out, 32'h0);
    check("mid rst state",   32'(debug_state), 32'(IDLE));
    m_sda_low = 1'b0;
    #T scl = 1'b1;
    #T rst_n = 1'b1;
    #T;
    snap_hits();
    i2c_start();
    send_byte(8'hAA, a0);
    send_byte(8'h00, a1);
    send_byte(8'h5A, a2);
    i2c_stop();
    strobe_delta(seen, total);
    check("post rst acks",    32'({a0, a1, a2}), 32'h0);
    check("post rst reg_out", reg_out, 32'h0000_005A);
    check("post rst strobe",  32'(seen), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
